// File: rtl/mvb_delim_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mvb_delim_detect                                                |
// | Purpose  : MVB start-delimiter detector. Synchronises and glitch-filters   |
// |            the raw Manchester line, recovers half-bit timing from edges,   |
// |            collects start bit + 8-bit delimiter and classifies the frame   |
// |            as master or slave. Feeds frame_start to the decoder.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mvb_delim_detect #(
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_LEN  = 3,
  parameter int                  HALF_BIT    = 8,
  parameter int                  PAT_LEN     = 18,
  parameter logic [PAT_LEN-1:0]  MASTER_PAT  = 18'b10_11_00_01_11_00_01_01_01,
  parameter logic [PAT_LEN-1:0]  SLAVE_PAT   = 18'b10_10_10_10_00_11_10_00_11,
  parameter logic                IDLE_LEVEL  = 1'b1,
  parameter int                  IDLE_CYCLES = 48
) (
  input  logic clk_24M,
  input  logic rst,
  input  logic en,
  input  logic data_in,
  output logic rx_level,
  output logic frame_start,
  output logic frame_type,
  output logic delim_err,
  output logic busy
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int HB_W   = $clog2(HALF_BIT);
  localparam int SYM_W  = $clog2(PAT_LEN + 1);
  localparam int IDL_W  = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [FCNT_W-1:0]      filt_cnt;
  logic                   filt_hit;
  logic                   rx_level_d;
  logic                   rx_edge;

  state_t                 state;
  logic [HB_W-1:0]        hb_cnt;
  logic [SYM_W-1:0]       sym_cnt;
  logic [PAT_LEN-1:0]     shreg;
  logic [PAT_LEN-1:0]     shift_nxt;
  logic [IDL_W-1:0]       idle_cnt;
  logic                   strobe;
  logic                   idle_expire;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous line.
  always_ff @(posedge clk_24M) begin
    if (!rst) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
  end

  // The filtered level flips only after FILTER_LEN consecutive differing samples.
  assign filt_hit = (synced != rx_level) && (filt_cnt == FCNT_W'(FILTER_LEN - 1));

  // Glitch filter: any sample equal to the current level restarts the count.
  always_ff @(posedge clk_24M) begin
    if (!rst) begin
      rx_level <= IDLE_LEVEL;
      filt_cnt <= '0;
    end else if (synced == rx_level) begin
      filt_cnt <= '0;
    end else if (filt_hit) begin
      rx_level <= synced;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Delayed copy of the filtered level; an edge is the cycle rx_level changes.
  always_ff @(posedge clk_24M) begin
    if (!rst) rx_level_d <= IDLE_LEVEL;
    else      rx_level_d <= rx_level;
  end

  assign rx_edge     = (rx_level != rx_level_d);
  // An edge reloads the phase counter, so it also suppresses the sample.
  assign strobe      = (hb_cnt == HB_W'(HALF_BIT/2 - 1)) && !rx_edge;
  assign shift_nxt   = {shreg[PAT_LEN-2:0], rx_level};
  assign idle_expire = !rx_edge && (idle_cnt == IDL_W'(IDLE_CYCLES - 1));

  // Delimiter FSM: hunt for the pattern, then ignore frame data until the bus idles.
  always_ff @(posedge clk_24M) begin
    if (!rst) begin
      state       <= S_IDLE;
      hb_cnt      <= '0;
      sym_cnt     <= '0;
      shreg       <= '0;
      idle_cnt    <= '0;
      frame_start <= 1'b0;
      frame_type  <= 1'b0;
      delim_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      delim_err   <= 1'b0;
      if (!en) begin
        state    <= S_IDLE;
        hb_cnt   <= '0;
        sym_cnt  <= '0;
        idle_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            hb_cnt   <= '0;
            idle_cnt <= '0;
            sym_cnt  <= '0;
            if (rx_edge && (rx_level != IDLE_LEVEL)) begin
              // The leading half of the start bit looks like idle and yields no
              // edge, so it is entered here as the first received symbol.
              state   <= S_HUNT;
              busy    <= 1'b1;
              shreg   <= {{(PAT_LEN-1){1'b0}}, IDLE_LEVEL};
              sym_cnt <= SYM_W'(1);
            end
          end

          S_HUNT: begin
            if (rx_edge)                                hb_cnt <= '0;
            else if (hb_cnt == HB_W'(HALF_BIT - 1))     hb_cnt <= '0;
            else                                        hb_cnt <= hb_cnt + 1'b1;
            idle_cnt <= rx_edge ? '0 : idle_cnt + 1'b1;

            if (idle_expire) begin
              delim_err <= 1'b1;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else if (strobe) begin
              shreg   <= shift_nxt;
              sym_cnt <= sym_cnt + 1'b1;
              if (sym_cnt == SYM_W'(PAT_LEN - 1)) begin
                state <= S_FRAME;
                if (shift_nxt == MASTER_PAT) begin
                  frame_start <= 1'b1;
                  frame_type  <= 1'b0;
                end else if (shift_nxt == SLAVE_PAT) begin
                  frame_start <= 1'b1;
                  frame_type  <= 1'b1;
                end else begin
                  delim_err   <= 1'b1;
                end
              end
            end
          end

          S_FRAME: begin
            hb_cnt   <= '0;
            sym_cnt  <= '0;
            idle_cnt <= rx_edge ? '0 : idle_cnt + 1'b1;
            if (idle_expire) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvb_delim_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mvb_delim_detect                                             |
// | Purpose  : Self-checking bench for mvb_delim_detect: table of delimiter    |
// |            vectors, randomized frames against a symbol-level model, and    |
// |            hand-written glitch / reset / enable / timeout sequences.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mvb_delim_detect;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
  localparam int HB          = 8;
  localparam int PL          = 18;
  localparam int IC          = 48;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN;
  localparam logic [17:0] MPAT = 18'b10_11_00_01_11_00_01_01_01;
  localparam logic [17:0] SPAT = 18'b10_10_10_10_00_11_10_00_11;
  localparam logic [17:0] ONES = 18'b10_10_10_10_10_10_10_10_10;
  localparam logic [17:0] MBAD = 18'b10_11_00_01_11_00_01_01_10;

  logic clk_24M = 1'b0;
  logic rst     = 1'b0;
  logic en      = 1'b0;
  logic data_in = 1'b1;
  logic rx_level, frame_start, frame_type, delim_err, busy;

  mvb_delim_detect #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .HALF_BIT(HB),
    .PAT_LEN(PL), .MASTER_PAT(MPAT), .SLAVE_PAT(SPAT),
    .IDLE_LEVEL(1'b1), .IDLE_CYCLES(IC)
  ) dut (
    .clk_24M(clk_24M), .rst(rst), .en(en), .data_in(data_in),
    .rx_level(rx_level), .frame_start(frame_start), .frame_type(frame_type),
    .delim_err(delim_err), .busy(busy)
  );

  always #5 clk_24M = ~clk_24M;

  typedef struct {
    logic [17:0] pat;
    logic        jit;
    int          exp_fs;
    int          exp_type;
    int          exp_de;
  } vec_t;

  vec_t tbl[6];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   base    = 0;
  int   both_n  = 0;
  int   fs_n, fs_t, de_n, rx_chg, busy_hi, busy_fall_t;
  logic fs_type, busy_at_de, prev_rx, prev_busy;
  logic s_rx, s_fs, s_ft, s_de, s_busy;
  logic wave[$];
  logic syms[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    fs_n = 0; fs_t = -1; de_n = 0; rx_chg = 0; busy_hi = 0; busy_fall_t = -1;
    fs_type = 1'b0; busy_at_de = 1'b0; prev_rx = 1'b1; prev_busy = 1'b0;
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the line.
  task automatic step(input logic d);
    @(posedge clk_24M);
    #1;
    cyc++;
    s_rx = rx_level; s_fs = frame_start; s_ft = frame_type;
    s_de = delim_err; s_busy = busy;
    if (frame_start) begin fs_n++; fs_t = cyc; fs_type = frame_type; end
    if (delim_err) begin de_n++; busy_at_de = busy; end
    if (frame_start && delim_err) both_n++;
    if (rx_level != prev_rx) rx_chg++;
    prev_rx = rx_level;
    if (busy) busy_hi++;
    if (prev_busy && !busy) busy_fall_t = cyc;
    prev_busy = busy;
    data_in = d;
  endtask

  task automatic run_wave();
    base = cyc;
    foreach (wave[i]) step(wave[i]);
  endtask

  task automatic add_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lvl);
  endtask

  task automatic push_pat_n(input logic [17:0] p, input int n);
    for (int i = PL - 1; i >= PL - n; i--) syms.push_back(p[i]);
  endtask

  // Manchester data: '1' = high then low, '0' = low then high.
  task automatic push_data(input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = 1'($urandom_range(1, 0));
      syms.push_back(b);
      syms.push_back(!b);
    end
  endtask

  // Turn the half-bit symbol list into a per-cycle line waveform. With jitter,
  // each edge moves by -2..+2 cycles, but no run shrinks by 4 or more so every
  // half-bit stays longer than the mid-half-bit sample point.
  task automatic build(input int pre, input int post, input logic jit);
    int   tt[$];
    logic lv[$];
    int   off, prev_off, n, k;
    logic cur;
    wave.delete();
    cur = 1'b1;
    prev_off = 0;
    for (int i = 0; i < syms.size(); i++) begin
      if (syms[i] != cur) begin
        off = jit ? int'($urandom_range(4, 0)) - 2 : 0;
        if (off - prev_off < -3) off = prev_off - 3;
        tt.push_back(pre + i * HB + off);
        lv.push_back(syms[i]);
        cur = syms[i];
        prev_off = off;
      end
    end
    if (cur != 1'b1) begin
      tt.push_back(pre + syms.size() * HB);
      lv.push_back(1'b1);
    end
    n = pre + syms.size() * HB + post;
    cur = 1'b1;
    k = 0;
    for (int t = 0; t < n; t++) begin
      if (k < tt.size() && tt[k] == t) begin
        cur = lv[k];
        k++;
      end
      wave.push_back(cur);
    end
  endtask

  // Reference classification: 0 master, 1 slave, 2 neither.
  function automatic int classify(input logic [17:0] p);
    if (p == MPAT) return 0;
    if (p == SPAT) return 1;
    return 2;
  endfunction

  initial begin
    int          t0, lw, lc, d, kind, exp_c;
    logic [17:0] p;
    logic        b;

    tbl[0] = '{MPAT, 1'b0, 1, 0, 0};
    tbl[1] = '{SPAT, 1'b1, 1, 1, 0};
    tbl[2] = '{ONES, 1'b0, 0, 0, 1};
    tbl[3] = '{MBAD, 1'b0, 0, 0, 1};
    tbl[4] = '{SPAT, 1'b0, 1, 1, 0};
    tbl[5] = '{MPAT, 1'b1, 1, 0, 0};

    // Reset state
    clear_stats();
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) step(1'b1);
    check("reset_rx_level",    s_rx,   1);
    check("reset_frame_start", s_fs,   0);
    check("reset_frame_type",  s_ft,   0);
    check("reset_delim_err",   s_de,   0);
    check("reset_busy",        s_busy, 0);
    rst = 1'b1;
    repeat (5) step(1'b1);

    // Glitches on the idle line: 1-cycle, 2-cycle and two 1-cycle pulses
    wave.delete();
    add_level(1'b1, 10); add_level(1'b0, 1); add_level(1'b1, 10);
    add_level(1'b0, 2);  add_level(1'b1, 10); add_level(1'b0, 1);
    add_level(1'b1, 1);  add_level(1'b0, 1);  add_level(1'b1, 60);
    clear_stats();
    run_wave();
    check("glitch_rx_changes", rx_chg,  0);
    check("glitch_busy",       busy_hi, 0);
    check("glitch_fs",         fs_n,    0);
    check("glitch_de",         de_n,    0);

    // Table-driven delimiter vectors
    for (int v = 0; v < 6; v++) begin
      syms.delete();
      push_pat_n(tbl[v].pat, PL);
      push_data(10);
      build(20, 80, tbl[v].jit);
      clear_stats();
      run_wave();
      check($sformatf("vec%0d_fs_count", v), fs_n, tbl[v].exp_fs);
      check($sformatf("vec%0d_de_count", v), de_n, tbl[v].exp_de);
      if (tbl[v].exp_fs == 1) check($sformatf("vec%0d_type", v), fs_type, tbl[v].exp_type);
      if (tbl[v].exp_de == 1) check($sformatf("vec%0d_busy_at_err", v), busy_at_de, 1);
      check($sformatf("vec%0d_busy_end", v), prev_busy, 0);
      if (v == 0) begin
        t0 = -1;
        foreach (wave[i]) if (t0 < 0 && wave[i] == 1'b0) t0 = i;
        t0 = base + 1 + t0;
        check("master_fs_time", fs_t, t0 + LAT + (PL - 2) * HB + HB / 2 + 1);
        lw = 0;
        for (int i = 1; i < wave.size(); i++) if (wave[i] != wave[i-1]) lw = i;
        lc = base + 1 + lw + LAT;
        d  = busy_fall_t - lc;
        check("master_busy_drop_window", int'(d >= IC && d <= IC + 1), 1);
      end
    end

    // Randomized frames against the symbol-level model
    for (int r = 0; r < 10; r++) begin
      kind = int'($urandom_range(2, 0));
      if (kind == 0)      p = MPAT;
      else if (kind == 1) p = SPAT;
      else begin
        p[17:16] = 2'b10;
        for (int k = 0; k < 8; k++) begin
          b = 1'($urandom_range(1, 0));
          p[15 - 2*k] = b;
          p[14 - 2*k] = !b;
        end
      end
      exp_c = classify(p);
      syms.delete();
      push_pat_n(p, PL);
      push_data(int'($urandom_range(14, 6)));
      build(20, 80, 1'b1);
      clear_stats();
      run_wave();
      check($sformatf("rnd%0d_fs_count", r), fs_n, (exp_c < 2) ? 1 : 0);
      check($sformatf("rnd%0d_de_count", r), de_n, (exp_c == 2) ? 1 : 0);
      if (exp_c < 2) check($sformatf("rnd%0d_type", r), fs_type, exp_c);
    end

    // Master delimiter whose frame data contains the slave pattern
    syms.delete();
    push_pat_n(MPAT, PL); push_pat_n(SPAT, PL); push_data(4);
    build(20, 80, 1'b0);
    clear_stats();
    run_wave();
    check("noretrig_fs_count", fs_n,    1);
    check("noretrig_type",     fs_type, 0);
    check("noretrig_de_count", de_n,    0);
    syms.delete();
    push_pat_n(SPAT, PL); push_data(4);
    build(20, 80, 1'b0);
    clear_stats();
    run_wave();
    check("later_slave_fs_count", fs_n,    1);
    check("later_slave_type",     fs_type, 1);

    // Reset pulse after 10 symbols of a master delimiter
    syms.delete();
    push_pat_n(MPAT, 10);
    build(20, 12, 1'b0);
    clear_stats();
    run_wave();
    check("rst_abort_busy_before", s_busy, 1);
    rst = 1'b0;
    step(1'b1);
    rst = 1'b1;
    check("rst_abort_rx_level", s_rx,   1);
    check("rst_abort_fs",       s_fs,   0);
    check("rst_abort_type",     s_ft,   0);
    check("rst_abort_de",       s_de,   0);
    check("rst_abort_busy",     s_busy, 0);
    repeat (70) step(1'b1);
    check("rst_abort_pulses", fs_n + de_n, 0);
    syms.delete();
    push_pat_n(MPAT, PL); push_data(6);
    build(20, 80, 1'b0);
    clear_stats();
    run_wave();
    check("after_rst_fs_count", fs_n,    1);
    check("after_rst_type",     fs_type, 0);

    // Enable dropped mid-HUNT
    syms.delete();
    push_pat_n(SPAT, 10);
    build(20, 12, 1'b0);
    clear_stats();
    run_wave();
    check("en_abort_busy_before", s_busy, 1);
    en = 1'b0;
    repeat (3) step(1'b1);
    check("en_abort_busy", s_busy, 0);
    check("en_abort_type_held", s_ft, 0);
    en = 1'b1;
    repeat (70) step(1'b1);
    check("en_abort_pulses", fs_n + de_n, 0);
    syms.delete();
    push_pat_n(SPAT, PL); push_data(6);
    build(20, 80, 1'b0);
    clear_stats();
    run_wave();
    check("after_en_fs_count", fs_n,    1);
    check("after_en_type",     fs_type, 1);

    // HUNT timeout: line falls and stays low
    syms.delete();
    syms.push_back(1'b1);
    for (int i = 0; i < 12; i++) syms.push_back(1'b0);
    build(20, 80, 1'b0);
    clear_stats();
    run_wave();
    check("timeout_de_count", de_n, 1);
    check("timeout_fs_count", fs_n, 0);
    check("timeout_busy_len", int'(busy_hi >= IC && busy_hi <= IC + 1), 1);
    check("timeout_busy_end", prev_busy, 0);

    check("fs_de_overlap", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvb_delim_detect.md
Name: mvb_delim_detect

Overview:
- Parametrised MVB start-delimiter detector; replaces the single-edge frame-start check.
- Synchronises and glitch-filters the raw Manchester line.
- Recovers half-bit timing by re-aligning on every edge, collects the start bit plus 8-bit delimiter as half-bit symbols, and classifies the frame as master or slave.
- Sits between the line receiver and the Manchester decoder; the decoder's frame_start source.

Parameters:
- SYNC_STAGES, 2: input synchroniser flops (>=2).
- FILTER_LEN, 3: consecutive identical synced samples required to change the filtered level (>=1).
- HALF_BIT, 8: clk_24M cycles per half-bit (1.5 Mbit/s), even, >=4.
- PAT_LEN, 18: half-bit symbols compared (start bit + 8 delimiter bits, 2 symbols each).
- MASTER_PAT, 18'b10_11_00_01_11_00_01_01_01: master pattern, MSB = first received; '1'=10, '0'=01, NH=11, NL=00.
- SLAVE_PAT, 18'b10_10_10_10_00_11_10_00_11: slave pattern, same encoding.
- IDLE_LEVEL, 1: line level when the bus is quiet.
- IDLE_CYCLES, 48: edge-free cycles that count as bus idle.

Ports:
- clk_24M  in  1  24 MHz clock
- rst  in  1  synchronous active-low reset
- en  in  1  detector enable
- data_in  in  1  raw asynchronous line
- rx_level  out  1  filtered line level
- frame_start  out  1  one-cycle pulse on delimiter match
- frame_type  out  1  0=master, 1=slave; valid with frame_start, held until next match
- delim_err  out  1  one-cycle pulse when PAT_LEN symbols match neither pattern
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at clk edge):
  - Synchroniser flops, filter level and rx_level = IDLE_LEVEL.
  - Filter count, half-bit counter, symbol count and shift register = 0.
  - State = IDLE.
  - frame_start, frame_type, delim_err, busy = 0.
  - Reset mid-frame aborts with no pulse.
- en=0: forces IDLE and clears the counters; frame_start and delim_err stay 0; the synchroniser and filter keep running.
- Filter:
  - rx_level toggles in the cycle the FILTER_LEN-th consecutive differing synced sample is seen.
  - A shorter pulse leaves rx_level unchanged.
  - An edge means rx_level changes.
- State IDLE: on a filtered edge away from IDLE_LEVEL, go to HUNT. Clear the half-bit counter and symbol count.
- State HUNT:
  - The half-bit counter counts 0..HALF_BIT-1 and wraps.
  - Every edge reloads the counter to 0.
  - Sample strobe when counter == HALF_BIT/2-1: shift rx_level into the PAT_LEN shift register (LSB in) and increment the symbol count.
  - On the strobe that completes PAT_LEN symbols, compare in the next cycle:
    - Equal to MASTER_PAT: frame_start=1, frame_type=0.
    - Equal to SLAVE_PAT: frame_start=1, frame_type=1.
    - Neither: delim_err=1.
  - Then go to FRAME.
  - The compare uses the full PAT_LEN-bit word. MASTER_PAT has priority if the parameters are equal.
- State FRAME:
  - No compare and no pulses (frame data cannot retrigger).
  - The edge-free counter counts up and clears on every edge. At IDLE_CYCLES, go to IDLE.
- Timeout:
  - The same edge-free counter also runs in HUNT.
  - Reaching IDLE_CYCLES in HUNT gives delim_err pulse, then IDLE.
- Simultaneous edge and strobe: the reload wins; no sample is taken that cycle.
- Counter widths are $clog2 of their maximum +1. All counters saturate or wrap as stated, with no overflow elsewhere.
- busy is registered; frame_start and delim_err are never high together.

Test Plan:
- Master delimiter, ideal 8-cycle half-bits from idle high, then 20 data half-bits:
  - Exactly one frame_start pulse with frame_type=0, one cycle after the 18th strobe.
  - delim_err stays 0.
  - busy drops 48 cycles after the last edge.
- Slave delimiter with each edge shifted randomly by ±2 cycles: one frame_start with frame_type=1.
- 1- and 2-cycle low glitches on the idle line (FILTER_LEN=3): rx_level stays 1, busy stays 0, no pulses.
- Pattern 10_10_10_10_10_10_10_10_10 (all '1' bits): one delim_err pulse, no frame_start, then FRAME then IDLE.
- Valid master delimiter followed by frame data that contains SLAVE_PAT: no second frame_start until 48 idle cycles pass; a later slave delimiter is then detected.
- rst=0 for one cycle after 10 symbols, or en dropped mid-HUNT:
  - All outputs 0 and IDLE.
  - A following complete delimiter is detected normally.
